serial_pattern_gen: RTL and testbench
=====================================

Name: serial_pattern_gen

Overview:
- Serial bit-stream transmitter: the driving end of the single-bit `in` line consumed by the team's Moore sequence detectors (1101 family).
- Serializes a programmable PAT_W-bit pattern, MSB first, a programmable number of times, with optional idle gaps between repetitions.
- Used as stimulus source and as on-chip link driver for detector blocks; one bit per clock, all outputs registered.

Parameters:
- PAT_W, 4, pattern width in bits (2..16).
- PATTERN, 4'b1101, reset/default pattern value (PAT_W bits).
- CNT_W, 8, width of repetition count.
- GAP_W, 4, width of inter-pattern gap count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin transmission; sampled only in IDLE.
- load_pat  input  1  write pattern_in into pattern register; sampled only in IDLE.
- pattern_in  input  PAT_W  new pattern value.
- repeat_cnt  input  CNT_W  number of pattern repetitions, latched on start.
- gap_cycles  input  GAP_W  idle cycles between repetitions, latched on start.
- out  output  1  serial data bit.
- valid  output  1  out carries a pattern bit this cycle.
- pat_sent  output  1  one-cycle pulse coincident with the last bit of each pattern.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the final repetition.

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE, out=0, valid=0, pat_sent=0, busy=0, done=0, pattern register=PATTERN, counters=0. Reset mid-transmission aborts immediately; no done pulse.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - load_pat=1 → pattern register <= pattern_in.
  - start=1 → latch repeat_cnt and gap_cycles.
    - If repeat_cnt==0 → DONE.
    - Else → SEND with bit index = PAT_W-1.
  - load_pat and start in the same cycle: the new pattern is used for this transmission.
- Latency: start sampled at edge k; first bit (MSB) appears on out with valid=1 after edge k+1 (1-cycle start-to-data latency).
- SEND:
  - out = pattern[idx], valid=1; idx decrements each cycle.
  - On idx==0: pat_sent=1 in the same cycle; remaining repetitions decrement.
  - If repetitions remain: go to GAP if gap>0, else re-enter SEND at idx=PAT_W-1 (back-to-back, no bubble).
  - If none remain: go to DONE.
- GAP: out=0, valid=0 for exactly gap_cycles cycles, then SEND.
- DONE: done=1, busy=1, out=0, valid=0 for one cycle, then IDLE. busy drops the cycle after done.
- Outside SEND: out=0, valid=0.
- start and load_pat are ignored while busy. Pattern register and latched counts are stable for the whole transmission.
- Repetition counter is CNT_W bits, no wrap: repeat_cnt = 2^CNT_W-1 is sent in full.

Optional Feature:
- Macro: SERIAL_PATTERN_GEN_PARITY_EN.
- Defined:
  - After the last pattern bit of each repetition, one extra SEND cycle outputs the even-parity bit (XOR of the pattern) with valid=1.
  - pat_sent moves to the parity cycle.
  - Gap and done timing shift by +1 cycle per repetition.
- Undefined: no parity cycle; behaviour exactly as above.

Test Plan:
- Reset values: assert rst for 2 cycles → out=0, valid=0, busy=0, done=0, pat_sent=0. Then start, repeat=1, gap=0 → out=1,1,0,1 with valid=1 over 4 cycles starting 1 cycle after start; pat_sent on the 4th bit; done the next cycle; busy falls the cycle after that.
- Back-to-back repetitions: repeat=3, gap=0 → out=110111011101 over 12 contiguous valid cycles; pat_sent on bits 4, 8, 12; a 1101 detector on out flags three times.
- Gap insertion and zero repeat:
  - repeat=2, gap=2 → 1101, 2 cycles with valid=0/out=0, then 1101, then done.
  - repeat=0 → done the cycle after start; valid never asserted.
- Pattern load: load_pat=1, pattern_in=4'b1011, and start in the same IDLE cycle → out=1,0,1,1.
  - Next start without load → still 1011.
  - After rst → default 1101.
- Ignored input and mid-operation reset: start and load_pat pulsed while busy → no effect on stream or pattern. rst asserted on bit 2 of repeat=3 → next cycle IDLE, out=0, no done pulse.
- Parity build (SERIAL_PATTERN_GEN_PARITY_EN defined): pattern 1101, repeat=1 → out=1,1,0,1,1; pat_sent on the 5th cycle; done on the 6th.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
// ------------------
// Serial bit-stream transmitter driving the single-bit `in` line of the
// 1101-family sequence detectors. A PAT_W-bit pattern is shifted out MSB
// first, repeat_cnt times, with gap_cycles idle cycles between repetitions.
// One bit per clock; every output is a register. Reset is synchronous and
// active-high.
//
// Build option:
//   SERIAL_PATTERN_GEN_PARITY_EN - after the last pattern bit of each
//   repetition, one extra valid cycle carries the even-parity bit (XOR of
//   the pattern). pat_sent then marks that parity cycle, and every
//   repetition (and therefore gap and done timing) is one cycle longer.
//
// Timing model: the control FSM decides what the current cycle transmits,
// and the output registers capture that decision on the next edge. So a
// start sampled at edge k puts the MSB on `out` after edge k+1, and done /
// busy trail the FSM state by one cycle in the same way.

module serial_pattern_gen #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_pat,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             out,
  output logic             valid,
  output logic             pat_sent,
  output logic             busy,
  output logic             done
);

  // Bit-index width; a 2-bit pattern still needs one index bit.
  localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  // FSM encoding kept as plain constants so that legacy wave scripts can
  // keep decoding the state bus numerically.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [PAT_W-1:0] pat_q;      // pattern in use; frozen while busy
  logic [IDX_W-1:0] idx;        // bit currently being transmitted
  logic [CNT_W-1:0] reps_left;  // repetitions not yet finished
  logic [GAP_W-1:0] gap_len;    // gap length latched at start
  logic [GAP_W-1:0] gap_cnt;    // remaining gap cycles minus one

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  logic             par_phase;  // this SEND cycle carries the parity bit
`endif

  // Per-cycle decisions derived from the FSM state.
  logic             send_bit;   // bit value transmitted this cycle
  logic             rep_end;    // this cycle completes a repetition
  logic             last_rep;   // the completing repetition is the final one

  // Decode the current cycle: which bit goes out and whether a repetition ends.
  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    send_bit = 1'b0;
    rep_end  = 1'b0;
    last_rep = (reps_left == CNT_W'(1));
    if (state == S_SEND) begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      send_bit = par_phase ? (^pat_q) : pat_q[idx];
      rep_end  = par_phase;
`else
      send_bit = pat_q[idx];
      rep_end  = (idx == '0);
`endif
    end
  end

  // Control FSM: pattern register, latched counts, bit index and gap timer.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values, independent of block order.
  // NOTE: the pattern register is reset to PATTERN on purpose, because a
  // start without a prior load must transmit the default pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pat_q     <= PATTERN;
      idx       <= '0;
      reps_left <= '0;
      gap_len   <= '0;
      gap_cnt   <= '0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      par_phase <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // load_pat and start in the same cycle: pat_q is written here and
          // first read in SEND, so the new pattern is the one transmitted.
          if (load_pat) begin
            pat_q <= pattern_in;
          end
          if (start) begin
            reps_left <= repeat_cnt;
            gap_len   <= gap_cycles;
            idx       <= IDX_MSB;
            state     <= (repeat_cnt == '0) ? S_DONE : S_SEND;
          end
        end

        S_SEND: begin
          if (rep_end) begin
            // Repetition complete: count it and pick the next phase. The
            // count is compared against one rather than decremented past
            // zero, so the all-ones repeat count is sent in full.
            reps_left <= reps_left - 1'b1;
            idx       <= IDX_MSB;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            par_phase <= 1'b0;
`endif
            if (last_rep) begin
              state <= S_DONE;
            end else if (gap_len != '0) begin
              gap_cnt <= gap_len - 1'b1;
              state   <= S_GAP;
            end
            // else: stay in SEND, MSB of the next repetition follows directly
          end else begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            if (idx == '0) begin
              par_phase <= 1'b1;
            end else begin
              idx <= idx - 1'b1;
            end
`else
            idx <= idx - 1'b1;
`endif
          end
        end

        S_GAP: begin
          // Visited exactly gap_len times before the next repetition.
          if (gap_cnt == '0) begin
            state <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output registers: capture what the FSM transmits this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= 1'b0;
      valid    <= 1'b0;
      pat_sent <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      out      <= send_bit;
      valid    <= (state == S_SEND);
      pat_sent <= rep_end;
      busy     <= (state != S_IDLE);
      done     <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen
// ---------------------
// Scoreboard bench for serial_pattern_gen. The driver issues transmissions
// and pushes the expected bit stream (value, pat_sent flag, absolute cycle)
// and the expected done cycle into queues, computed from the pattern,
// repetition and gap rules. An independent monitor pops and compares
// whenever the DUT presents valid or done. Directed cases come first,
// followed by randomized transmissions.

module tb_serial_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
  localparam logic [PAT_W-1:0] DEF_PAT = 4'b1101;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             load_pat = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap_cycles = '0;
  logic             out, valid, pat_sent, busy, done;

  serial_pattern_gen #(
    .PAT_W(PAT_W), .PATTERN(DEF_PAT), .CNT_W(CNT_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .load_pat(load_pat),
    .pattern_in(pattern_in), .repeat_cnt(repeat_cnt), .gap_cycles(gap_cycles),
    .out(out), .valid(valid), .pat_sent(pat_sent), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic ps;
    int   cyc;
  } exp_t;

  exp_t sb_q[$];
  int   done_q[$];
  int   cyc      = 0;
  int   done_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  logic [PAT_W-1:0] model_pat = DEF_PAT;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected stream for one transmission whose start is
  // sampled at edge k. Bits appear from edge k+1 onward.
  task automatic push_model(input int k, input int reps, input int gap);
    int c;
    c = k + 1;
    for (int r = 0; r < reps; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        sb_q.push_back('{b: model_pat[b], ps: (b == 0) && !PAR, cyc: c});
        c++;
      end
      if (PAR) begin
        sb_q.push_back('{b: ^model_pat, ps: 1'b1, cyc: c});
        c++;
      end
      if (r < reps - 1) c += gap;
    end
    done_q.push_back(c);
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", {31'b0, valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("bit_value", {31'b0, out}, {31'b0, e.b});
          check("bit_pat_sent", {31'b0, pat_sent}, {31'b0, e.ps});
          check("bit_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_out_pat_sent", {30'b0, out, pat_sent}, 32'd0);
      end
      if (done) begin
        check("busy_during_done", {31'b0, busy}, 32'd1);
        if (done_q.size() == 0) begin
          check("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
        done_cnt++;
      end
    end
  end

  // One transmission; optionally pulses start/load_pat while busy.
  task automatic xmit(input bit ld, input logic [PAT_W-1:0] pin,
                      input int reps, input int gap, input bit disturb);
    int target;
    int t;
    if (ld) model_pat = pin;
    start      = 1'b1;
    load_pat   = ld;
    pattern_in = pin;
    repeat_cnt = CNT_W'(reps);
    gap_cycles = GAP_W'(gap);
    push_model(cyc + 1, reps, gap);
    target = done_cnt + 1;
    @(posedge clk); #1;
    start      = 1'b0;
    load_pat   = 1'b0;
    pattern_in = PAT_W'($urandom);
    repeat_cnt = CNT_W'($urandom);
    gap_cycles = GAP_W'($urandom);
    t = 0;
    while (done_cnt < target && t < 3000) begin
      if (disturb && t == 3) begin
        start      = 1'b1;
        load_pat   = 1'b1;
        pattern_in = ~model_pat;
      end else if (disturb && t == 4) begin
        start    = 1'b0;
        load_pat = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt < target) begin
      check("done_timeout", done_cnt, target);
      sb_q.delete();
      done_q.delete();
    end else begin
      check("busy_after_done", {31'b0, busy}, 32'd0);
    end
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    sb_q.delete();
    done_q.delete();
    model_pat = DEF_PAT;
    check("rst_out_valid", {30'b0, out, valid}, 32'd0);
    check("rst_busy_done", {30'b0, busy, done}, 32'd0);
    check("rst_pat_sent", {31'b0, pat_sent}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    apply_reset(2);
    mon_en = 1'b1;

    // Basic, back-to-back, gaps, zero repeat.
    xmit(1'b0, '0, 1, 0, 1'b0);
    xmit(1'b0, '0, 3, 0, 1'b0);
    xmit(1'b0, '0, 2, 2, 1'b0);
    xmit(1'b0, '0, 0, 5, 1'b0);

    // Pattern load with start, then reuse, then reset restores default.
    xmit(1'b1, 4'b1011, 1, 0, 1'b0);
    xmit(1'b0, '0, 1, 0, 1'b0);
    apply_reset(1);
    xmit(1'b0, '0, 1, 0, 1'b0);

    // Start/load pulsed while busy must not disturb stream or pattern.
    xmit(1'b0, '0, 3, 1, 1'b1);
    xmit(1'b0, '0, 1, 0, 1'b0);

    // Reset in the middle of a transmission: abort, no done pulse.
    begin
      int d0;
      d0 = done_cnt;
      start      = 1'b1;
      repeat_cnt = CNT_W'(3);
      gap_cycles = '0;
      push_model(cyc + 1, 3, 0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      apply_reset(1);
      repeat (3) begin @(posedge clk); #1; end
      check("no_done_after_abort", done_cnt, d0);
      check("idle_after_abort", {30'b0, busy, valid}, 32'd0);
    end

    // Randomized transmissions.
    for (int i = 0; i < 25; i++) begin
      xmit(1'($urandom), PAT_W'($urandom), int'($urandom_range(0, 4)),
           int'($urandom_range(0, 15)), 1'($urandom));
    end

    // Largest repeat count is sent in full.
    xmit(1'b1, 4'b1001, (1 << CNT_W) - 1, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
